// File: rtl/pwm_compare8.sv
// ---------------------------------------------------------------------------
// pwm_compare8
//
// PWM generator that sits downstream of the free-running 8-bit up-counter.
// It compares the incoming count against a double-buffered duty value, so a
// new duty only ever takes effect at a period boundary (counter wrap
// 255 -> 0).
//
// The block also:
//   - detects the wrap itself;
//   - counts completed periods;
//   - holds the PWM output low after enable until a complete period can be
//     produced.
//
// Ports
//   clk_i         : single clock, shared with the counter
//   rst_ni        : asynchronous active-low reset
//   en_i          : PWM enable
//   cnt_i[7:0]    : counter value (the counter's cnt_o)
//   duty_i[7:0]   : new duty value, high-time in counts
//   duty_we_i     : write strobe for duty_i
//   pwm_o         : registered PWM output
//   wrap_o        : one-cycle pulse per detected 255 -> 0 wrap
//   duty_act_o    : duty value currently used by the comparator
//   period_cnt_o  : completed-period counter, wraps 255 -> 0
//   run_o         : high while the PWM is actively driving (RUN state)
//
// All outputs are registered. pwm_o lags cnt_i by exactly one clock, which
// keeps the duty ratio exact.
// ---------------------------------------------------------------------------
module pwm_compare8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] cnt_i,
  input  logic [7:0] duty_i,
  input  logic       duty_we_i,
  output logic       pwm_o,
  output logic       wrap_o,
  output logic [7:0] duty_act_o,
  output logic [7:0] period_cnt_o,
  output logic       run_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [7:0] duty_pend_q;
  logic       pend_valid_q;
  logic [7:0] duty_act_q;
  logic [7:0] period_cnt_q;
  logic       pwm_q;
  logic       wrap_q;
  logic       run_q;

  logic       wrap;
  logic [7:0] duty_nxt;
  logic       cmp_hi;

  // A wrap is only the exact FF -> 00 step.
  // Loads, holds and counter resets produce other discontinuities and are
  // deliberately ignored. A count held at FF for several cycles still gives
  // a single wrap, because only the final FF -> 00 step matches.
  assign wrap = (cnt_q == 8'hFF) && (cnt_i == 8'h00);

  // On the wrap cycle the pending duty is used immediately, so the first
  // compare of the new period already sees the new value.
  assign duty_nxt = (wrap && pend_valid_q) ? duty_pend_q : duty_act_q;

  assign cmp_hi = (cnt_i < duty_nxt);

  // Previous counter sample, used only for wrap detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_i;
    end
  end

  // Duty double buffer.
  // The promotion to the active register uses the old pending value, so a
  // write arriving in the same cycle as a wrap becomes pending for the
  // following period. Repeated writes inside one period simply overwrite
  // the pending value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_pend_q  <= 8'h00;
      pend_valid_q <= 1'b0;
      duty_act_q   <= 8'h00;
    end else begin
      if (wrap && pend_valid_q) begin
        duty_act_q <= duty_pend_q;
      end
      if (duty_we_i) begin
        duty_pend_q  <= duty_i;
        pend_valid_q <= 1'b1;
      end else if (wrap) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  // Wrap pulse and period counter.
  // Both run in every FSM state, so software can see periods elapsing even
  // while the output is disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrap_q       <= 1'b0;
      period_cnt_q <= 8'h00;
    end else begin
      wrap_q <= wrap;
      if (wrap) begin
        period_cnt_q <= period_cnt_q + 8'd1;
      end
    end
  end

  // Output FSM.
  // SYNC waits for a wrap so that the first high pulse after enable is a
  // full period. The SYNC -> RUN edge already drives pwm from the compare.
  // Dropping the enable forces the output low on that same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pwm_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pwm_q <= 1'b0;
          run_q <= 1'b0;
          if (en_i) begin
            state_q <= SYNC;
          end
        end
        SYNC: begin
          if (!en_i) begin
            state_q <= IDLE;
            pwm_q   <= 1'b0;
            run_q   <= 1'b0;
          end else if (wrap) begin
            state_q <= RUN;
            pwm_q   <= cmp_hi;
            run_q   <= 1'b1;
          end else begin
            pwm_q <= 1'b0;
            run_q <= 1'b0;
          end
        end
        RUN: begin
          if (!en_i) begin
            state_q <= IDLE;
            pwm_q   <= 1'b0;
            run_q   <= 1'b0;
          end else begin
            pwm_q <= cmp_hi;
            run_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          pwm_q   <= 1'b0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_o        = pwm_q;
  assign wrap_o       = wrap_q;
  assign duty_act_o   = duty_act_q;
  assign period_cnt_o = period_cnt_q;
  assign run_o        = run_q;

endmodule

// File: tb/tb_pwm_compare8.sv
// ---------------------------------------------------------------------------
// tb_pwm_compare8
//
// Drives pwm_compare8 from a software counter and compares every output on
// every cycle against a period-level reference model.
//
// Period-level checks:
//   - directed scenarios also count high cycles over whole periods;
//   - they count wrap pulses across loads and holds.
//
// Duty values are randomized with $urandom, and so is the duty-write
// traffic.
// ---------------------------------------------------------------------------
module tb_pwm_compare8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] cnt_val;
  logic [7:0] duty;
  logic       duty_we;
  logic       pwm;
  logic       wrap;
  logic [7:0] duty_act;
  logic [7:0] period_cnt;
  logic       run;

  bit cnt_run;

  int n_vectors;
  int n_compares;
  int n_miscompares;
  int hi_count;
  int wrap_count;

  // Reference model: output phase of the PWM and the buffered duties
  localparam int PH_OFF  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_ON   = 2;

  int         m_phase;
  logic [7:0] m_prev_cnt;
  logic [7:0] m_pend;
  bit         m_pend_valid;
  logic [7:0] m_act;
  logic [7:0] m_period;
  logic       m_pwm;
  logic       m_wrap;

  pwm_compare8 dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .cnt_i        (cnt_val),
    .duty_i       (duty),
    .duty_we_i    (duty_we),
    .pwm_o        (pwm),
    .wrap_o       (wrap),
    .duty_act_o   (duty_act),
    .period_cnt_o (period_cnt),
    .run_o        (run)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    m_phase      = PH_OFF;
    m_prev_cnt   = 8'h00;
    m_pend       = 8'h00;
    m_pend_valid = 0;
    m_act        = 8'h00;
    m_period     = 8'h00;
    m_pwm        = 1'b0;
    m_wrap       = 1'b0;
  endtask

  // One clock of the model.
  // A period boundary is seen only on the step 255 -> 0. The pwm level for
  // the next cycle is "count below the duty of the period being produced".
  task automatic modelClock();
    bit         boundary;
    logic [7:0] period_duty;
    if (!rst_n) begin
      modelReset();
      return;
    end
    boundary    = (m_prev_cnt == 8'd255) && (cnt_val == 8'd0);
    period_duty = (boundary && m_pend_valid) ? m_pend : m_act;
    case (m_phase)
      PH_OFF: begin
        m_pwm = 1'b0;
        if (en) m_phase = PH_WAIT;
      end
      PH_WAIT: begin
        if (!en) begin
          m_phase = PH_OFF;
          m_pwm   = 1'b0;
        end else if (boundary) begin
          m_phase = PH_ON;
          m_pwm   = (int'(cnt_val) < int'(period_duty));
        end else begin
          m_pwm = 1'b0;
        end
      end
      default: begin
        if (!en) begin
          m_phase = PH_OFF;
          m_pwm   = 1'b0;
        end else begin
          m_pwm = (int'(cnt_val) < int'(period_duty));
        end
      end
    endcase
    if (boundary && m_pend_valid) begin
      m_act        = m_pend;
      m_pend_valid = 0;
    end
    if (duty_we) begin
      m_pend       = duty;
      m_pend_valid = 1;
    end
    m_wrap = boundary;
    if (boundary) m_period = m_period + 8'd1;
    m_prev_cnt = cnt_val;
  endtask

  task automatic checkValue(input string tag, input logic [8:0] observed,
                            input logic [8:0] expected);
    n_compares++;
    assert (observed === expected)
    else begin
      n_miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue("pwm_o", {8'd0, pwm}, {8'd0, m_pwm});
    checkValue("wrap_o", {8'd0, wrap}, {8'd0, m_wrap});
    checkValue("duty_act_o", {1'b0, duty_act}, {1'b0, m_act});
    checkValue("period_cnt_o", {1'b0, period_cnt}, {1'b0, m_period});
    checkValue("run_o", {8'd0, run}, {8'd0, logic'(m_phase == PH_ON)});
  endtask

  // One clock: the edge, the model step, a check #1 later, then advance the
  // software counter and drop the one-shot write strobe.
  task automatic applyStimulus();
    @(posedge clk);
    modelClock();
    #1;
    n_vectors++;
    checkOutput();
    if (pwm === 1'b1) hi_count++;
    if (wrap === 1'b1) wrap_count++;
    if (cnt_run) cnt_val = cnt_val + 8'd1;
    duty_we = 1'b0;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic runUntilCnt(input logic [7:0] target);
    int guard;
    guard = 0;
    while (cnt_val != target && guard < 600) begin
      applyStimulus();
      guard++;
    end
    if (cnt_val != target) checkValue("cnt_timeout", {1'b0, cnt_val}, {1'b0, target});
  endtask

  task automatic runUntilWrap();
    bit seen;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      applyStimulus();
      if (wrap === 1'b1) seen = 1;
    end
    if (!seen) checkValue("wrap_timeout", 9'd0, 9'd1);
  endtask

  task automatic writeDuty(input logic [7:0] value);
    duty    = value;
    duty_we = 1'b1;
    applyStimulus();
  endtask

  initial begin
    n_vectors     = 0;
    n_compares    = 0;
    n_miscompares = 0;
    hi_count      = 0;
    wrap_count    = 0;
    modelReset();
    rst_n   = 1'b0;
    en      = 1'b0;
    cnt_val = 8'd200;
    duty    = 8'd0;
    duty_we = 1'b0;
    cnt_run = 1;

    $display("[TB] reset");
    runCycles(3);
    rst_n = 1'b1;

    $display("[TB] basic pwm at duty 64");
    writeDuty(8'd64);
    en = 1'b1;
    runUntilWrap();
    checkValue("basic_duty_act", {1'b0, duty_act}, 9'd64);
    checkValue("basic_run", {8'd0, run}, 9'd1);
    hi_count = 0;
    runCycles(256);
    checkValue("basic_high64", 9'(hi_count), 9'd64);

    $display("[TB] double buffering");
    runUntilCnt(8'd100);
    writeDuty(8'd200);
    checkValue("dbuf_keep64", {1'b0, duty_act}, 9'd64);
    runUntilWrap();
    checkValue("dbuf_act200", {1'b0, duty_act}, 9'd200);
    hi_count = 0;
    runCycles(256);
    checkValue("dbuf_high200", 9'(hi_count), 9'd200);

    $display("[TB] write coincident with wrap");
    runUntilCnt(8'd50);
    writeDuty(8'd30);
    runUntilCnt(8'd0);
    writeDuty(8'd128);
    checkValue("coinc_old_pending", {1'b0, duty_act}, 9'd30);
    runUntilWrap();
    checkValue("coinc_next_period", {1'b0, duty_act}, 9'd128);

    $display("[TB] random duty traffic");
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        duty    = 8'($urandom_range(0, 255));
        duty_we = 1'b1;
      end
      applyStimulus();
    end

    $display("[TB] load is not a wrap");
    runUntilCnt(8'd30);
    wrap_count = 0;
    cnt_val = 8'd240;
    runUntilCnt(8'd10);
    checkValue("load_one_wrap", 9'(wrap_count), 9'd1);

    $display("[TB] edge duties");
    writeDuty(8'd0);
    runUntilWrap();
    hi_count = 0;
    runCycles(256);
    checkValue("duty0_high", 9'(hi_count), 9'd0);
    writeDuty(8'd255);
    runUntilWrap();
    hi_count = 0;
    runCycles(256);
    checkValue("duty255_high", 9'(hi_count), 9'd255);

    $display("[TB] held counter");
    writeDuty(8'($urandom_range(1, 254)));
    runUntilCnt(8'd77);
    cnt_run = 0;
    wrap_count = 0;
    runCycles(10);
    checkValue("static_no_wrap", 9'(wrap_count), 9'd0);
    cnt_run = 1;
    runUntilCnt(8'd255);
    cnt_run = 0;
    runCycles(5);
    cnt_run = 1;
    runCycles(3);
    checkValue("hold_ff_one_wrap", 9'(wrap_count), 9'd1);

    $display("[TB] enable toggle");
    writeDuty(8'd255);
    runUntilWrap();
    runUntilCnt(8'd10);
    en = 1'b0;
    applyStimulus();
    checkValue("en_off_pwm", {8'd0, pwm}, 9'd0);
    checkValue("en_off_run", {8'd0, run}, 9'd0);
    runUntilCnt(8'd50);
    en = 1'b1;
    hi_count = 0;
    runUntilCnt(8'd0);
    checkValue("en_sync_quiet", 9'(hi_count), 9'd0);
    applyStimulus();
    checkValue("en_resume_run", {8'd0, run}, 9'd1);
    checkValue("en_resume_pwm", {8'd0, pwm}, 9'd1);

    $display("[TB] reset mid-operation");
    runUntilCnt(8'd120);
    writeDuty(8'd9);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkValue("async_pwm", {8'd0, pwm}, 9'd0);
    checkValue("async_period", {1'b0, period_cnt}, 9'd0);
    checkValue("async_duty_act", {1'b0, duty_act}, 9'd0);
    checkValue("async_run", {8'd0, run}, 9'd0);
    runCycles(2);
    rst_n = 1'b1;
    runUntilWrap();
    checkValue("post_reset_period", {1'b0, period_cnt}, 9'd1);
    checkValue("post_reset_no_pending", {1'b0, duty_act}, 9'd0);
    runCycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
